// File: rtl/xrog_frame_scheduler.sv
// Round-robin frame scheduler that hands one requester's frame at a time to the governance engine.
// Define XROG_SCHED_STATS_EN to build the frames_done / frames_aborted statistics counters.
module xrog_frame_scheduler #(
    parameter int NUM_REQ     = 4,
    parameter int FRAME_W     = 4096,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ-1:0][FRAME_W-1:0]  req_frame,
    output logic [NUM_REQ-1:0]               req_ready,
    output logic [FRAME_W-1:0]               eng_frame_out,
    output logic                             eng_valid,
    input  logic                             eng_busy,
    input  logic                             eng_done,
    output logic [2:0]                       grant_id,
    output logic [1:0]                       sched_state,
    output logic                             timeout_err,
    output logic [15:0]                      frames_done,
    output logic [15:0]                      frames_aborted
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYC - 1);

    state_t             state;
    state_t             state_next;
    logic [2:0]         last_grant;
    logic [2:0]         winner;
    logic               found;
    int                 rr_dist;
    int                 rr_best;
    logic [FRAME_W-1:0] sel_frame;
    logic [15:0]        cyc_cnt;
    logic               accept;
    logic               timeout_evt;

    // The winner is the pending requester at the smallest circular distance after last_grant.
    always_comb begin
        winner  = '0;
        rr_dist = 0;
        rr_best = NUM_REQ;
        for (int c = 0; c < NUM_REQ; c++) begin
            rr_dist = (c + 2 * NUM_REQ - 1 - int'(last_grant)) % NUM_REQ;
            if (req_valid[c] && (rr_dist < rr_best)) begin
                rr_best = rr_dist;
                winner  = 3'(c);
            end
        end
    end

    assign found = |req_valid;

    always_comb begin
        sel_frame = '0;
        for (int c = 0; c < NUM_REQ; c++) begin
            if (winner == 3'(c)) sel_frame = req_frame[c];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (found) state_next = RUN;
            RUN:     if (eng_done || (cyc_cnt == TIMEOUT_LAST)) state_next = DRAIN;
            DRAIN:   if (!eng_busy) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // eng_done has priority over the timeout when both land in the same cycle.
    always_comb begin
        req_ready   = '0;
        eng_valid   = 1'b0;
        accept      = 1'b0;
        timeout_evt = 1'b0;
        case (state)
            IDLE: begin
                if (rst_n && found) begin
                    accept    = 1'b1;
                    req_ready = NUM_REQ'(1) << winner;
                end
            end
            RUN: begin
                eng_valid   = 1'b1;
                timeout_evt = !eng_done && (cyc_cnt == TIMEOUT_LAST);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            eng_frame_out <= '0;
            grant_id      <= '0;
            last_grant    <= 3'(NUM_REQ - 1);
            cyc_cnt       <= '0;
            timeout_err   <= 1'b0;
        end else begin
            if (accept) begin
                eng_frame_out <= sel_frame;
                grant_id      <= winner;
                last_grant    <= winner;
            end
            if (accept)            cyc_cnt <= '0;
            else if (state == RUN) cyc_cnt <= cyc_cnt + 16'd1;
            if (timeout_evt) timeout_err <= 1'b1;
        end
    end

    assign sched_state = state;

`ifdef XROG_SCHED_STATS_EN
    logic        done_evt;
    logic [15:0] done_cnt;
    logic [15:0] abort_cnt;

    assign done_evt = (state == RUN) && eng_done;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            done_cnt  <= '0;
            abort_cnt <= '0;
        end else begin
            if (done_evt && (done_cnt != 16'hFFFF))     done_cnt  <= done_cnt + 16'd1;
            if (timeout_evt && (abort_cnt != 16'hFFFF)) abort_cnt <= abort_cnt + 16'd1;
        end
    end

    assign frames_done    = done_cnt;
    assign frames_aborted = abort_cnt;
`else
    assign frames_done    = '0;
    assign frames_aborted = '0;
`endif

endmodule

// File: tb/tb_xrog_frame_scheduler.sv
// Scoreboard bench for xrog_frame_scheduler: randomized requests and engine behaviour against a transaction-level model.
module tb_xrog_frame_scheduler;

    localparam int NR = 4;
    localparam int FW = 64;
    localparam int TO = 16;
`ifdef XROG_SCHED_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic [NR-1:0]           req_valid;
    logic [NR-1:0][FW-1:0]   req_frame;
    logic [NR-1:0]           req_ready;
    logic [FW-1:0]           eng_frame_out;
    logic                    eng_valid;
    logic                    eng_busy;
    logic                    eng_done;
    logic [2:0]              grant_id;
    logic [1:0]              sched_state;
    logic                    timeout_err;
    logic [15:0]             frames_done;
    logic [15:0]             frames_aborted;

    always #5 clk = ~clk;

    xrog_frame_scheduler #(
        .NUM_REQ     (NR),
        .FRAME_W     (FW),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_frame      (req_frame),
        .req_ready      (req_ready),
        .eng_frame_out  (eng_frame_out),
        .eng_valid      (eng_valid),
        .eng_busy       (eng_busy),
        .eng_done       (eng_done),
        .grant_id       (grant_id),
        .sched_state    (sched_state),
        .timeout_err    (timeout_err),
        .frames_done    (frames_done),
        .frames_aborted (frames_aborted)
    );

    typedef struct {
        int            id;
        logic [FW-1:0] frame;
    } grant_t;

    typedef struct {
        int            len;
        int            state;
        int            gid;
        logic [FW-1:0] frame;
        logic          terr;
        int            done_n;
        int            abort_n;
    } outcome_t;

    grant_t   grant_q[$];
    outcome_t out_q[$];

    int   checks  = 0;
    int   errors  = 0;
    int   m_last  = NR - 1;
    int   m_done  = 0;
    int   m_abort = 0;
    logic m_terr  = 1'b0;
    bit   mon_en  = 1'b0;
    bit   mon_stop = 1'b0;

    grant_t   mon_cur;
    outcome_t mon_out;
    bit       mon_chk_next = 1'b0;
    bit       mon_prev_valid = 1'b0;
    int       mon_run_len = 0;

    task automatic checkOutput(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // First pending requester after the previous grant, walking the ring.
    function automatic int rr_pick(input int last, input logic [NR-1:0] v);
        for (int s = 1; s <= NR; s++) begin
            int c;
            c = (last + s) % NR;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [FW-1:0] rand_frame();
        return {$urandom, $urandom};
    endfunction

    // One transaction: k = RUN cycle of eng_done (-1 never), reset_at = RUN cycle of a reset (-1 none).
    task automatic applyStimulus(input logic [NR-1:0] pat, input int k, input int drain, input int reset_at);
        int       w;
        int       len;
        grant_t   g;
        outcome_t o;
        @(negedge clk);
        req_valid = pat;
        for (int i = 0; i < NR; i++) req_frame[i] = rand_frame();
        eng_done = 1'b0;
        eng_busy = 1'($urandom_range(0, 1));
        w = rr_pick(m_last, pat);
        m_last = w;
        g.id = w;
        g.frame = req_frame[w];
        grant_q.push_back(g);
        if (reset_at >= 0) begin
            len = reset_at + 1;
            m_last = NR - 1;
            m_done = 0;
            m_abort = 0;
            m_terr = 1'b0;
            o = '{len, 0, 0, '0, 1'b0, 0, 0};
        end else if (k >= 0) begin
            len = k + 1;
            if (m_done < 65535) m_done++;
            o = '{len, 2, w, g.frame, m_terr, STATS ? m_done : 0, STATS ? m_abort : 0};
        end else begin
            len = TO;
            if (m_abort < 65535) m_abort++;
            m_terr = 1'b1;
            o = '{len, 2, w, g.frame, m_terr, STATS ? m_done : 0, STATS ? m_abort : 0};
        end
        out_q.push_back(o);
        for (int j = 0; j < len; j++) begin
            @(negedge clk);
            req_valid = NR'($urandom);
            for (int i = 0; i < NR; i++) req_frame[i] = rand_frame();
            eng_done = (j == k);
            if (j == reset_at) rst_n = 1'b0;
        end
        if (reset_at >= 0) begin
            @(negedge clk);
            rst_n = 1'b1;
            req_valid = '0;
            eng_done = 1'b0;
        end else begin
            for (int i = 0; i <= drain; i++) begin
                @(negedge clk);
                eng_done = 1'($urandom_range(0, 1));
                eng_busy = (i < drain);
                req_valid = NR'($urandom_range(1, (1 << NR) - 1));
            end
        end
    endtask

    task automatic applyIdle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            req_valid = '0;
            eng_done = 1'($urandom_range(0, 1));
            eng_busy = 1'($urandom_range(0, 1));
        end
    endtask

    // Monitor: pops the scoreboard whenever a grant or a transaction end is visible.
    initial begin : monitor
        wait (mon_en);
        while (!mon_stop) begin
            @(negedge clk);
            #2;
            if (mon_chk_next) begin
                mon_chk_next = 1'b0;
                mon_run_len = 0;
                checkOutput("valid_latency", FW'(eng_valid), FW'(1));
                checkOutput("grant_id", FW'(grant_id), FW'(mon_cur.id));
                checkOutput("frame_latch", eng_frame_out, mon_cur.frame);
            end
            if (req_ready !== '0) begin
                if (grant_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_grant: req_ready=%b expected 0", req_ready);
                end else begin
                    mon_cur = grant_q.pop_front();
                    checkOutput("req_ready", FW'(req_ready), FW'(1) << mon_cur.id);
                    checkOutput("grant_state", FW'(sched_state), FW'(0));
                    mon_chk_next = 1'b1;
                end
            end
            if (eng_valid === 1'b1) mon_run_len++;
            if (mon_prev_valid && (eng_valid !== 1'b1)) begin
                if (out_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_end: run of %0d cycles with no transaction expected", mon_run_len);
                end else begin
                    mon_out = out_q.pop_front();
                    checkOutput("run_len", FW'(mon_run_len), FW'(mon_out.len));
                    checkOutput("end_state", FW'(sched_state), FW'(mon_out.state));
                    checkOutput("end_grant_id", FW'(grant_id), FW'(mon_out.gid));
                    checkOutput("end_frame", eng_frame_out, mon_out.frame);
                    checkOutput("timeout_err", FW'(timeout_err), FW'(mon_out.terr));
                    checkOutput("frames_done", FW'(frames_done), FW'(mon_out.done_n));
                    checkOutput("frames_aborted", FW'(frames_aborted), FW'(mon_out.abort_n));
                end
            end
            mon_prev_valid = (eng_valid === 1'b1);
        end
    end

    initial begin : driver
        int mode;
        int k;
        rst_n = 1'b0;
        req_valid = '1;
        req_frame = '0;
        eng_busy = 1'b0;
        eng_done = 1'b0;
        @(posedge clk);
        mon_en = 1'b1;
        repeat (2) @(negedge clk);
        #2;
        checkOutput("rst_eng_valid", FW'(eng_valid), FW'(0));
        checkOutput("rst_frame", eng_frame_out, '0);
        checkOutput("rst_grant_id", FW'(grant_id), FW'(0));
        checkOutput("rst_state", FW'(sched_state), FW'(0));
        checkOutput("rst_timeout_err", FW'(timeout_err), FW'(0));
        checkOutput("rst_frames_done", FW'(frames_done), FW'(0));
        checkOutput("rst_frames_aborted", FW'(frames_aborted), FW'(0));
        checkOutput("rst_req_ready", FW'(req_ready), FW'(0));
        @(negedge clk);
        rst_n = 1'b1;
        req_valid = '0;

        applyStimulus(4'b0100, 9, 2, -1);
        applyStimulus(4'b1111, -1, 0, 4);
        repeat (5) applyStimulus(4'b1111, $urandom_range(0, 5), $urandom_range(0, 2), -1);
        applyStimulus(NR'($urandom_range(1, 15)), TO - 1, 0, -1);
        applyStimulus(NR'($urandom_range(1, 15)), -1, 1, -1);
        applyIdle(2);

        for (int t = 0; t < 40; t++) begin
            mode = $urandom_range(0, 9);
            if (mode < 2)       k = -1;
            else if (mode == 2) k = TO - 1;
            else                k = $urandom_range(0, 12);
            if (t == 25) applyStimulus(NR'($urandom_range(1, 15)), -1, 0, $urandom_range(0, 10));
            else         applyStimulus(NR'($urandom_range(1, 15)), k, $urandom_range(0, 3), -1);
            if ($urandom_range(0, 3) == 0) applyIdle($urandom_range(1, 2));
        end

        @(negedge clk);
        req_valid = '0;
        eng_done = 1'b0;
        for (int i = 0; (i < 20) && ((grant_q.size() != 0) || (out_q.size() != 0)); i++) @(negedge clk);
        checks++;
        if ((grant_q.size() != 0) || (out_q.size() != 0)) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: %0d grants and %0d ends outstanding, expected 0", grant_q.size(), out_q.size());
        end
        mon_stop = 1'b1;
        @(negedge clk);
        #3;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
